// File: rtl/echo_delay_meas.sv
// echo_delay_meas
//   Launches a probe edge into a delay path, watches the returned echo and
//   reports the round-trip delay in clk cycles. A direct probe->echo wire
//   reports 1; every register stage in the loop adds 1.
//
// Parameters
//   CNT_W     width of the cycle counter and of delay_cnt
//   TIMEOUT   maximum cycles spent in any waiting state (2 .. 2^CNT_W-1)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      request one measurement (only looked at while idle)
//   echo       returned signal from the delay path
//   probe      launched edge into the delay path
//   busy       high while a measurement is in progress
//   done       one-cycle pulse, delay_cnt holds a fresh measurement
//   tmo        one-cycle pulse, a wait expired
//   delay_cnt  last valid measured delay, held until the next done
//
// Build option
//   ECHO_DELAY_MEAS_SYNC_EN  when defined, echo goes through a 2-flop
//   synchronizer and the reported delay is compensated by the 2 cycles the
//   synchronizer adds (timeouts still use the raw count).
module echo_delay_meas #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             echo,
  output logic             probe,
  output logic             busy,
  output logic             done,
  output logic             tmo,
  output logic [CNT_W-1:0] delay_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_LOW = 2'd1;
  localparam logic [1:0] S_LAUNCH   = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [CNT_W:0] TMO_LIM = TIMEOUT[CNT_W:0];

`ifdef ECHO_DELAY_MEAS_SYNC_EN
  localparam logic [CNT_W-1:0] SYNC_LAT = {{(CNT_W-2){1'b0}}, 2'd2};
`endif

  // Remove the synchronizer latency from a raw round-trip count, never
  // going below zero.
  function automatic logic [CNT_W-1:0] comp_delay(input logic [CNT_W-1:0] raw);
`ifdef ECHO_DELAY_MEAS_SYNC_EN
    if (raw < SYNC_LAT) return '0;
    return raw - SYNC_LAT;
`else
    return raw;
`endif
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             probe_q, probe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] delay_cnt_q, delay_cnt_d;
  logic             echo_s;
  logic [CNT_W:0]   cnt_inc;
  logic             cnt_exp;

`ifdef ECHO_DELAY_MEAS_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], echo};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign echo_s = sync_q[1];
`else
  assign echo_s = echo;
`endif

  // One extra bit so the expiry compare never sees a wrapped value.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_exp = (cnt_inc == TMO_LIM);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    probe_d     = probe_q;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    delay_cnt_d = delay_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (echo_s) begin
            // Echo is still high from something else: wait for it to
            // settle before launching, or the edge would be missed.
            state_d = S_WAIT_LOW;
          end else begin
            state_d = S_LAUNCH;
            probe_d = 1'b1;
          end
        end
      end

      S_WAIT_LOW: begin
        if (!echo_s) begin
          state_d = S_LAUNCH;
          probe_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_exp) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      S_LAUNCH: begin
        // Echo is checked first so a return on the expiry edge still
        // counts as a valid measurement.
        if (echo_s) begin
          state_d     = S_RELEASE;
          delay_cnt_d = comp_delay(cnt_inc[CNT_W-1:0]);
          done_d      = 1'b1;
          probe_d     = 1'b0;
          cnt_d       = '0;
        end else if (cnt_exp) begin
          state_d = S_RELEASE;
          tmo_d   = 1'b1;
          probe_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      S_RELEASE: begin
        // Expiry here is silent: the measurement already reported.
        if (!echo_s || cnt_exp) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        probe_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      probe_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      delay_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      probe_q     <= probe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      delay_cnt_q <= delay_cnt_d;
    end
  end

  assign probe     = probe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tmo       = tmo_q;
  assign delay_cnt = delay_cnt_q;

endmodule

// File: tb/tb_echo_delay_meas.sv
// Bench for echo_delay_meas: table of measurement scenarios driven through a
// configurable echo path, results checked by a scoreboard, plus hand-written
// reset, busy-release, race/ignore and mid-measurement reset sequences.
module tb_echo_delay_meas;

  localparam int CNT_W = 8;
  localparam int TMO   = 200;
`ifdef ECHO_DELAY_MEAS_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             echo;
  logic             probe, busy, done, tmo;
  logic [CNT_W-1:0] delay_cnt;

  // Echo path: forced high, manual level, or probe through 'depth' flops.
  logic       force_hi = 1'b0;
  logic       man_mode = 1'b1;
  logic       echo_drv = 1'b0;
  int         depth = 0;
  logic [7:0] sr = '0;
  logic       loop_echo;

  always @(posedge clk) sr <= {sr[6:0], probe};

  always_comb begin
    if (depth == 0) loop_echo = probe;
    else            loop_echo = sr[depth-1];
  end

  assign echo = force_hi ? 1'b1 : (man_mode ? echo_drv : loop_echo);

  echo_delay_meas #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .echo(echo),
    .probe(probe), .busy(busy), .done(done), .tmo(tmo),
    .delay_cnt(delay_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int delay;
    int lat;
    bit probe_seen;
  } exp_t;

  typedef struct {
    int mode;   // 0 loop, 1 echo stuck 0, 2 echo stuck 1, 3 forced high then loop
    int depth;
    exp_t exp;
  } vec_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int mark_cyc = 0;
  bit probe_seen = 0;
  bit busy_prev = 0;
  bit probe_prev = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done/tmo pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy && !busy_prev) begin
      mark_cyc   = cyc;
      probe_seen = probe;
    end
    if (probe && !probe_prev) begin
      mark_cyc   = cyc;
      probe_seen = 1'b1;
    end
    if (done || tmo) begin
      pulse_cnt++;
      check("done_tmo_exclusive", int'(done && tmo), 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_done", int'(done), int'(e.is_done));
        check("delay_cnt", int'(delay_cnt), e.delay);
        check("latency", cyc - mark_cyc, e.lat);
        check("probe_asserted", int'(probe_seen), int'(e.probe_seen));
      end
    end
    busy_prev  = busy;
    probe_prev = probe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_pulse(input int p0, input int budget, input string name);
    int n = 0;
    while (pulse_cnt == p0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pulse_cnt == p0) check({name, "_no_pulse"}, 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_stuck", 1, 0);
  endtask

  function automatic exp_t mk(bit d, int dl, int lt, bit ps);
    exp_t e;
    e.is_done = d; e.delay = dl; e.lat = lt; e.probe_seen = ps;
    return e;
  endfunction

  vec_t vecs[7];

  initial begin
    int p0;
    int n;

    vecs[0] = '{mode: 0, depth: 0, exp: mk(1, 1, 1 + SL, 1)};
    vecs[1] = '{mode: 0, depth: 4, exp: mk(1, 5, 5 + SL, 1)};
    vecs[2] = '{mode: 0, depth: 2, exp: mk(1, 3, 3 + SL, 1)};
    vecs[3] = '{mode: 1, depth: 0, exp: mk(0, 3, TMO, 1)};
    vecs[4] = '{mode: 3, depth: 3, exp: mk(1, 4, 4 + SL, 1)};
    vecs[5] = '{mode: 2, depth: 0, exp: mk(0, 4, TMO, 0)};
    vecs[6] = '{mode: 0, depth: 7, exp: mk(1, 8, 8 + SL, 1)};

    // Reset held with start high: everything stays cleared.
    rst = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_probe", int'(probe), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_tmo", int'(tmo), 0);
      check("rst_delay_cnt", int'(delay_cnt), 0);
    end
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;

    // Direct loopback: busy must release once the echo is seen low again.
    man_mode = 1'b0; depth = 0;
    repeat (10) @(posedge clk);
    sb.push_back(mk(1, 1, 1 + SL, 1));
    pulse_start();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    check("direct_done_seen", int'(done), 1);
    check("busy_at_done", int'(busy), 1);
    for (int k = 1; k <= 1 + SL; k++) begin
      @(negedge clk);
      check("busy_after_done", int'(busy), (k < 1 + SL) ? 1 : 0);
    end
    wait_idle(300);

    // Table-driven scenarios.
    for (int i = 0; i < 7; i++) begin
      man_mode = (vecs[i].mode == 1 || vecs[i].mode == 2);
      echo_drv = (vecs[i].mode == 2);
      force_hi = (vecs[i].mode == 3);
      depth    = vecs[i].depth;
      repeat (10) @(posedge clk);
      #1;
      sb.push_back(vecs[i].exp);
      p0 = pulse_cnt;
      pulse_start();
      if (vecs[i].mode == 3) begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("probe_low_while_echo_high", int'(probe), 0);
        end
        @(posedge clk); #1 force_hi = 1'b0;
      end
      wait_pulse(p0, 600, "vec");
      wait_idle(600);
    end
    man_mode = 1'b1; echo_drv = 1'b0; force_hi = 1'b0;

    // Echo arriving on the expiry edge wins; a second start in LAUNCH is dropped.
    repeat (10) @(posedge clk);
    sb.push_back(mk(1, TMO - SL, TMO, 1));
    p0 = pulse_cnt;
    pulse_start();
    repeat (50) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (TMO - 1 - SL - 51) @(posedge clk);
    #1 echo_drv = 1'b1;
    wait_pulse(p0, 100, "race");
    echo_drv = 1'b0;
    wait_idle(300);
    repeat (260) @(negedge clk);
    check("race_single_pulse", pulse_cnt - p0, 1);

    // Reset mid-LAUNCH with the counter at 7.
    repeat (10) @(posedge clk);
    p0 = pulse_cnt;
    pulse_start();
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_probe_before_rst", int'(probe), 1);
    check("mid_busy_before_rst", int'(busy), 1);
    @(negedge clk);
    check("mid_rst_probe", int'(probe), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_tmo", int'(tmo), 0);
    check("mid_rst_delay_cnt", int'(delay_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_pulse", pulse_cnt - p0, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
